// File: rtl/tx_link_arbiter.sv
// ---------------------------------------------------------------------------
// tx_link_arbiter
//   Round-robin arbiter that shares one 8-bit strobed transmit port among
//   NREQ requesters. Each granted word is sequenced as
//   IDLE -> SETUP -> STROBE -> GAP -> IDLE.
//
// Ports
//   hz100    in   system clock (rising edge)
//   reset    in   asynchronous active-low reset
//   req      in   per-requester level request
//   data     in   requester i's byte on data[8i+7:8i]
//   txready  in   peer ready; only looked at in IDLE
//   ack      out  one-hot, one-cycle pulse when a byte is captured
//   txdata   out  byte on the transmit port
//   txclk    out  transmit strobe (registered)
//   busy     out  high whenever not IDLE
//   gnt_id   out  index of the current / most recent winner
// ---------------------------------------------------------------------------
module tx_link_arbiter #(
  parameter  int NREQ       = 4,
  parameter  int STROBE_CYC = 2,
  parameter  int GAP_CYC    = 1,
  localparam int GW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              hz100,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] data,
  input  logic              txready,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        txdata,
  output logic              txclk,
  output logic              busy,
  output logic [GW-1:0]     gnt_id
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_GAP    = 2'd3;

  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] GAP_LOAD    = 4'(GAP_CYC - 1);

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [GW-1:0]   last_q, last_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [7:0]      txdata_q, txdata_d;
  logic            txclk_q, txclk_d;
  logic [NREQ-1:0] ack_q, ack_d;

  // Unpack the flat data bus into one byte per requester.
  logic [7:0] data_b [NREQ];
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign data_b[gi] = data[8*gi +: 8];
    end
  endgenerate

  // Round-robin pick: lowest requesting index above last grant if any,
  // otherwise wrap to the lowest requesting index overall.
  logic          any_req, hi_found;
  logic [GW-1:0] lowest_any, lowest_hi, win_idx;

  always_comb begin
    any_req    = 1'b0;
    hi_found   = 1'b0;
    lowest_any = '0;
    lowest_hi  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_req    = 1'b1;
        lowest_any = GW'(i);
        if (GW'(i) > last_q) begin
          hi_found  = 1'b1;
          lowest_hi = GW'(i);
        end
      end
    end
    win_idx = hi_found ? lowest_hi : lowest_any;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    txdata_d = txdata_q;
    txclk_d  = txclk_q;
    ack_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (txready && any_req) begin
          state_d  = ST_SETUP;
          txdata_d = data_b[win_idx];
          gnt_d    = win_idx;
          last_d   = win_idx;
          ack_d    = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = STROBE_LOAD;
        txclk_d = 1'b1;
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
          txclk_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      last_q   <= GW'(NREQ - 1);
      gnt_q    <= '0;
      txdata_q <= '0;
      txclk_q  <= 1'b0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      txdata_q <= txdata_d;
      txclk_q  <= txclk_d;
      ack_q    <= ack_d;
    end
  end

  assign ack    = ack_q;
  assign txdata = txdata_q;
  assign txclk  = txclk_q;
  assign gnt_id = gnt_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tx_link_arbiter.sv
module tb_tx_link_arbiter;

  logic        hz100;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] data;
  logic        txready;
  logic [3:0]  ack;
  logic [7:0]  txdata;
  logic        txclk;
  logic        busy;
  logic [1:0]  gnt_id;

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;
  logic [7:0] exp_b [4];

  tx_link_arbiter #(.NREQ(4), .STROBE_CYC(2), .GAP_CYC(1)) dut (
    .hz100  (hz100),
    .reset  (reset),
    .req    (req),
    .data   (data),
    .txready(txready),
    .ack    (ack),
    .txdata (txdata),
    .txclk  (txclk),
    .busy   (busy),
    .gnt_id (gnt_id)
  );

  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;
  always @(posedge hz100) edge_cnt <= edge_cnt + 1;

  task automatic tick();
    @(posedge hz100);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Bounded wait for IDLE; an expired bound counts as a failure.
  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL wait_idle: busy=%b required 0 within 10 cycles", busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req = '0; txready = 1'b0;
    #2;
    total++;
    if (ack !== 4'b0 || txdata !== 8'h00 || txclk !== 1'b0 || busy !== 1'b0 || gnt_id !== 2'd0) begin
      bad++;
      $display("FAIL reset_state: ack=%b txdata=%h txclk=%b busy=%b gnt=%0d required all 0", ack, txdata, txclk, busy, gnt_id);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req = 4'b0001; txready = 1'b1;
    tick();
    total++;
    if (ack !== 4'b0001 || txdata !== exp_b[0] || gnt_id !== 2'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_grant: ack=%b txdata=%h gnt=%0d busy=%b required 0001 %h 0 1", ack, txdata, gnt_id, busy, exp_b[0]);
    end
    $display("grant id=%0d byte=%h", gnt_id, txdata);
    req = 4'b0000;
    for (int e = 2; e <= 3; e++) begin
      tick();
      total++;
      if (txclk !== 1'b1 || ack !== 4'b0) begin
        bad++;
        $display("FAIL single_strobe edge%0d: txclk=%b ack=%b required 1 0000", e, txclk, ack);
      end
    end
    tick();
    total++;
    if (txclk !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_gap: txclk=%b busy=%b required 0 1", txclk, busy);
    end
    tick();
    total++;
    if (busy !== 1'b0 || txdata !== exp_b[0]) begin
      bad++;
      $display("FAIL single_idle: busy=%b txdata=%h required 0 %h", busy, txdata, exp_b[0]);
    end
  endtask

  task automatic test_round_robin();
    int last_edge = 0;
    int n;
    apply_reset();
    req = 4'b1111; txready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (ack === 4'b0 && n < 10);
      total++;
      if (ack !== (4'b0001 << (k % 4)) || gnt_id !== 2'(k % 4) || txdata !== exp_b[k % 4]) begin
        bad++;
        $display("FAIL rr_word%0d: ack=%b gnt=%0d txdata=%h required id %0d byte %h", k, ack, gnt_id, txdata, k % 4, exp_b[k % 4]);
      end
      $display("grant id=%0d byte=%h edge=%0d", gnt_id, txdata, edge_cnt);
      if (k > 0) begin
        total++;
        if (edge_cnt - last_edge != 5) begin
          bad++;
          $display("FAIL rr_spacing%0d: %0d edges required 5", k, edge_cnt - last_edge);
        end
      end
      last_edge = edge_cnt;
      tick();
      total++;
      if (ack !== 4'b0) begin
        bad++;
        $display("FAIL rr_ack_width%0d: ack=%b required 0000", k, ack);
      end
      if (k == 7) req = 4'b0000;
    end
    wait_idle();
  endtask

  task automatic test_txready_low();
    txready = 1'b0; req = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if (busy !== 1'b0 || ack !== 4'b0) begin
        bad++;
        $display("FAIL txready_hold c%0d: busy=%b ack=%b required 0 0000", c, busy, ack);
      end
    end
    txready = 1'b1;
    tick();
    total++;
    if (ack !== 4'b0100 || gnt_id !== 2'd2 || txdata !== exp_b[2]) begin
      bad++;
      $display("FAIL txready_rise: ack=%b gnt=%0d txdata=%h required 0100 2 %h", ack, gnt_id, txdata, exp_b[2]);
    end
    $display("grant id=%0d byte=%h", gnt_id, txdata);
    req = 4'b0000;
    wait_idle();
  endtask

  task automatic test_strobe_txready_drop();
    // last grant is 2, so requester 0 wins via wrap
    req = 4'b0001; txready = 1'b1;
    tick();
    total++;
    if (ack !== 4'b0001 || gnt_id !== 2'd0) begin
      bad++;
      $display("FAIL drop_grant: ack=%b gnt=%0d required 0001 0", ack, gnt_id);
    end
    $display("grant id=%0d byte=%h", gnt_id, txdata);
    req = 4'b0000;
    tick();
    txready = 1'b0;
    total++;
    if (txclk !== 1'b1) begin
      bad++;
      $display("FAIL drop_strobe1: txclk=%b required 1", txclk);
    end
    tick();
    total++;
    if (txclk !== 1'b1 || txdata !== exp_b[0]) begin
      bad++;
      $display("FAIL drop_strobe2: txclk=%b txdata=%h required 1 %h", txclk, txdata, exp_b[0]);
    end
    tick();
    total++;
    if (txclk !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL drop_gap: txclk=%b busy=%b required 0 1", txclk, busy);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL drop_idle: busy=%b required 0", busy);
    end
    txready = 1'b1;
  endtask

  task automatic test_reset_mid_strobe();
    req = 4'b0010;
    tick();
    total++;
    if (ack !== 4'b0010 || gnt_id !== 2'd1) begin
      bad++;
      $display("FAIL rst_pre_grant: ack=%b gnt=%0d required 0010 1", ack, gnt_id);
    end
    tick();
    total++;
    if (txclk !== 1'b1 || txdata !== exp_b[1]) begin
      bad++;
      $display("FAIL rst_pre_strobe: txclk=%b txdata=%h required 1 %h", txclk, txdata, exp_b[1]);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (txclk !== 1'b0 || txdata !== 8'h00 || ack !== 4'b0 || busy !== 1'b0 || gnt_id !== 2'd0) begin
      bad++;
      $display("FAIL rst_async: txclk=%b txdata=%h ack=%b busy=%b gnt=%0d required all 0", txclk, txdata, ack, busy, gnt_id);
    end
    tick();
    reset = 1'b1;
    tick();
    total++;
    if (ack !== 4'b0010 || gnt_id !== 2'd1 || txdata !== exp_b[1]) begin
      bad++;
      $display("FAIL rst_regrant: ack=%b gnt=%0d txdata=%h required 0010 1 %h", ack, gnt_id, txdata, exp_b[1]);
    end
    $display("grant id=%0d byte=%h", gnt_id, txdata);
    req = 4'b0000;
    tick();
    total++;
    if (ack !== 4'b0) begin
      bad++;
      $display("FAIL rst_single_ack: ack=%b required 0000", ack);
    end
    wait_idle();
  endtask

  task automatic test_gap_change();
    int g_edge;
    int n = 0;
    req = 4'b0100;
    tick();
    total++;
    if (ack !== 4'b0100 || gnt_id !== 2'd2) begin
      bad++;
      $display("FAIL gap_first: ack=%b gnt=%0d required 0100 2", ack, gnt_id);
    end
    $display("grant id=%0d byte=%h", gnt_id, txdata);
    req = 4'b0001;
    tick();
    tick();
    tick();
    total++;
    if (txclk !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL gap_state: txclk=%b busy=%b required 0 1", txclk, busy);
    end
    req = 4'b1001;
    tick();
    tick();
    total++;
    if (ack !== 4'b1000 || gnt_id !== 2'd3 || txdata !== exp_b[3]) begin
      bad++;
      $display("FAIL gap_to3: ack=%b gnt=%0d txdata=%h required 1000 3 %h", ack, gnt_id, txdata, exp_b[3]);
    end
    $display("grant id=%0d byte=%h", gnt_id, txdata);
    g_edge = edge_cnt;
    req = 4'b0001;
    do begin
      tick();
      n++;
    end while (ack === 4'b0 && n < 10);
    total++;
    if (ack !== 4'b0001 || gnt_id !== 2'd0 || edge_cnt - g_edge != 5) begin
      bad++;
      $display("FAIL gap_to0: ack=%b gnt=%0d spacing=%0d required 0001 0 5", ack, gnt_id, edge_cnt - g_edge);
    end
    $display("grant id=%0d byte=%h", gnt_id, txdata);
    req = 4'b0000;
    wait_idle();
  endtask

  initial begin
    exp_b[0] = 8'hA5; exp_b[1] = 8'h5A; exp_b[2] = 8'hC2; exp_b[3] = 8'hD3;
    data = {exp_b[3], exp_b[2], exp_b[1], exp_b[0]};
    reset = 1'b0; req = '0; txready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_txready_low();
    test_strobe_txready_drop();
    test_reset_mid_strobe();
    test_gap_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
